// File: rtl/jtdd2_sndcmd.sv
// ---------------------------------------------------------------------------
// jtdd2_sndcmd
//
// The main CPU side of the sound-latch/NMI link to the DD2 sound board.
// Main CPU byte writes go into a small FIFO. Each byte is placed on
// snd_latch and announced with a snd_irq pulse. The next byte is sent only
// after the sound CPU reads the latch (a rising edge on snd_ack), or after
// the optional timeout runs out.
//
// Parameters
//   AW       FIFO address width; the FIFO holds 2**AW entries
//   IRQ_W    snd_irq pulse width in clk cycles (>= 1)
//   TIMEOUT  cycles to wait for snd_ack after the pulse; 0 = wait forever
//
// Ports
//   clk        system clock
//   rst_n      synchronous reset, active low
//   cpu_wr     main CPU write strobe (one-cycle qualified pulse)
//   cpu_din    command byte
//   snd_latch  byte presented to the sound board latch
//   snd_irq    pulse that drives the sound-side NMI flip-flop
//   snd_ack    sound CPU latch-read select (level); rising edge = ack
//   full       FIFO holds 2**AW entries
//   empty      FIFO holds no entries
//   level      FIFO occupancy
//   busy       a command is in flight (state != IDLE)
//   drop       one-cycle pulse after a write was discarded because the
//              FIFO was full
//
// Handshake: a write is taken on every clk edge where cpu_wr=1 and full=0.
// full is judged before any pop in the same cycle, so a write while full is
// always discarded. On the sound side, snd_latch is valid from the edge that
// raises snd_irq. It holds until the next load. Only a 0->1 transition of
// snd_ack counts as an acknowledge.
// ---------------------------------------------------------------------------
module jtdd2_sndcmd #(
    parameter int          AW      = 2,
    parameter int          IRQ_W   = 4,
    parameter logic [15:0] TIMEOUT = 16'd0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_wr,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    snd_latch,
    output logic          snd_irq,
    input  logic          snd_ack,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          busy,
    output logic          drop
);

    localparam int DEPTH = 2 ** AW;
    localparam int PW    = (IRQ_W > 1) ? $clog2(IRQ_W) : 1;
    localparam logic [PW-1:0] PULSE_LOAD = PW'(IRQ_W - 1);
    localparam logic [15:0]   TO_LAST    = TIMEOUT - 16'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IRQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t        state_q, state_d;

    // FIFO storage and pointers. The pointers carry one extra bit, so
    // wr_ptr - rd_ptr gives the occupancy directly and full and empty
    // cannot be mistaken for each other.
    logic [7:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          push, pop;
    logic [7:0]    head;

    // Handshake and timing state
    logic          ack_q, ack_rise;
    logic          ack_seen, ack_seen_d;
    logic [PW-1:0] pcnt, pcnt_d;
    logic [15:0]   tcnt, tcnt_d;
    logic          irq_d;
    logic          load;

    // ------------------------------------------------------------------
    // FIFO status
    // ------------------------------------------------------------------
    assign level = wr_ptr - rd_ptr;
    assign empty = (level == '0);
    assign full  = (level == {1'b1, {AW{1'b0}}});
    assign head  = mem[rd_ptr[AW-1:0]];

    // full comes from the registered pointers, so a pop in the same cycle
    // cannot open up a slot for this write.
    assign push  = cpu_wr & ~full;
    assign pop   = load;

    assign ack_rise = snd_ack & ~ack_q;
    assign busy     = (state_q != ST_IDLE);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty) state_d = ST_IRQ;
            end
            ST_IRQ: begin
                // An ack that arrives during the pulse makes WAIT unnecessary.
                if (pcnt == '0) begin
                    if (ack_seen || ack_rise) state_d = ST_IDLE;
                    else                      state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ack_rise)
                    state_d = ST_IDLE;
                else if ((TIMEOUT != 16'd0) && (tcnt == TO_LAST))
                    state_d = ST_IDLE;      // give up on this command
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs / datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        load       = 1'b0;
        irq_d      = snd_irq;
        pcnt_d     = pcnt;
        tcnt_d     = tcnt;
        ack_seen_d = ack_seen;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    load       = 1'b1;
                    irq_d      = 1'b1;
                    pcnt_d     = PULSE_LOAD;
                    ack_seen_d = 1'b0;
                end
            end
            ST_IRQ: begin
                if (ack_rise) ack_seen_d = 1'b1;
                if (pcnt == '0) begin
                    irq_d  = 1'b0;
                    tcnt_d = 16'd0;
                end else begin
                    pcnt_d = pcnt - 1'b1;
                end
            end
            ST_WAIT: begin
                if (TIMEOUT != 16'd0) tcnt_d = tcnt + 16'd1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ack_q     <= 1'b0;
            ack_seen  <= 1'b0;
            pcnt      <= '0;
            tcnt      <= 16'd0;
            snd_irq   <= 1'b0;
            snd_latch <= 8'h00;
            drop      <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            ack_q     <= snd_ack;
            ack_seen  <= ack_seen_d;
            pcnt      <= pcnt_d;
            tcnt      <= tcnt_d;
            snd_irq   <= irq_d;
            // The latch changes only when a command starts, so it holds
            // still for the whole IRQ and WAIT period.
            if (load) snd_latch <= head;
            drop      <= cpu_wr & full;
        end
    end

    // The storage needs no reset. An entry is read only after it is written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= cpu_din;
    end

endmodule
